// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
//   Shared definitions for the SDRAM front-end arbiter:
//   - arbiter FSM state encoding (also exported on the debug state port)
//   - granted-operation encoding
//   - address / word widths of the controller request/response bundle
// ---------------------------------------------------------------------------
package sdram_pkg;

    // SDRAM controller address and data word widths
    localparam int ADDR_W    = 23;   // controller word address
    localparam int IWORD_W   = 32;   // instruction word
    localparam int DWORD_W   = 16;   // data word
    localparam int M_RDATA_W = IWORD_W;
    localparam int M_WDATA_W = DWORD_W;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_DONE   = 3'd3,
        ST_RESP   = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } arb_op_e;

endpackage

// File: rtl/ibuf_entry.sv
// ---------------------------------------------------------------------------
// ibuf_entry
//   One-entry instruction buffer: tag / data / valid register with a
//   combinational hit compare and a whole-entry invalidate.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset (entry invalid)
//   load_i         write tag/data and mark the entry valid
//   load_tag_i     tag (instruction word address) to store
//   load_data_i    instruction word to store
//   inval_i        clear the valid bit (wins over load_i)
//   lookup_tag_i   address to compare against the stored tag
//   hit_o          entry valid and tag matches lookup_tag_i
//   data_o         stored instruction word
// ---------------------------------------------------------------------------
module ibuf_entry
    import sdram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [ADDR_W-1:0]  load_tag_i,
    input  logic [IWORD_W-1:0] load_data_i,
    input  logic               inval_i,
    input  logic [ADDR_W-1:0]  lookup_tag_i,
    output logic               hit_o,
    output logic [IWORD_W-1:0] data_o
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  tag_q,   tag_d;
    logic [IWORD_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inval_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            tag_d   = load_tag_i;
            data_d  = load_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   CPU-side front end of the SDRAM controller. Merges the instruction-fetch
//   port and the data load/store port onto the controller's single request
//   interface (one access in flight) and keeps a one-entry instruction buffer
//   so a repeated fetch of the same word completes without an SDRAM access.
//
// Handshakes
//   CPU side: i_req / d_rd_req / d_wr_req are levels held (with address and
//   write data) until the matching one-cycle ack. Data is valid only while
//   the ack is high; err pulses with the ack when the access timed out.
//   Controller side: m_read_req / m_write_req are raised in ISSUE only when
//   m_busy=0 and held until m_busy=1 is seen. A read completes on the first
//   m_read_ready=1, a write on the first m_busy=0 after acceptance.
//
// Ports
//   clk, rst_n                CPU clock, asynchronous active-low reset
//   i_req, i_addr             fetch request / instruction word address
//   i_ack, i_data             fetch completion pulse / instruction word
//   d_rd_req, d_wr_req        data read / write request
//   d_addr, d_wdata, d_ispace data address, write data, write to I-space
//   d_ack, d_rdata            data completion pulse / read data
//   err                       timeout flag, pulses with an ack
//   m_addr, m_wdata           controller address / write data
//   m_read_req, m_write_req   controller requests
//   m_instr_mode              controller instruction-mode select
//   m_busy, m_read_ready      controller status
//   m_rdata                   controller read data
//   dbg_state                 current arbiter FSM state
// ---------------------------------------------------------------------------
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 1023,
    parameter int TO_W         = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_ack,
    output logic [IWORD_W-1:0]   i_data,
    input  logic                 d_rd_req,
    input  logic                 d_wr_req,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DWORD_W-1:0]   d_wdata,
    input  logic                 d_ispace,
    output logic                 d_ack,
    output logic [DWORD_W-1:0]   d_rdata,
    output logic                 err,
    output logic [ADDR_W-1:0]    m_addr,
    output logic [M_WDATA_W-1:0] m_wdata,
    output logic                 m_read_req,
    output logic                 m_write_req,
    output logic                 m_instr_mode,
    input  logic                 m_busy,
    input  logic                 m_read_ready,
    input  logic [M_RDATA_W-1:0] m_rdata,
    output logic [STATE_W-1:0]   dbg_state
);

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT);

    arb_state_e          state_q,  state_d;
    arb_op_e             op_q,     op_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DWORD_W-1:0]  wdata_q,  wdata_d;
    logic                imode_q,  imode_d;
    logic                rd_req_q, rd_req_d;
    logic                wr_req_q, wr_req_d;
    logic [IWORD_W-1:0]  rdata_q,  rdata_d;
    logic                to_err_q, to_err_d;   // current access timed out
    logic [SC_W-1:0]     starve_q, starve_d;
    logic [TO_W-1:0]     to_q,     to_d;
    logic                i_ack_q,  i_ack_d;
    logic                d_ack_q,  d_ack_d;
    logic                err_q,    err_d;
    logic [IWORD_W-1:0]  i_data_q, i_data_d;
    logic [DWORD_W-1:0]  d_rdata_q, d_rdata_d;

    logic                data_pending;
    logic                waiting;
    logic                timed_out;
    logic                buf_hit;
    logic [IWORD_W-1:0]  buf_data;
    logic                buf_load;
    logic                buf_inval;

    ibuf_entry u_ibuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (buf_load),
        .load_tag_i   (addr_q),
        .load_data_i  (rdata_q),
        .inval_i      (buf_inval),
        .lookup_tag_i (i_addr),
        .hit_o        (buf_hit),
        .data_o       (buf_data)
    );

    assign data_pending = d_rd_req || d_wr_req;
    assign waiting      = (state_q == ST_ISSUE) || (state_q == ST_ACCEPT) ||
                          (state_q == ST_DONE);
    assign timed_out    = (to_q == TO_MAX);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        imode_d   = imode_q;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        rdata_d   = rdata_q;
        to_err_d  = to_err_q;
        starve_d  = starve_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        i_data_d  = '0;
        d_rdata_d = '0;
        buf_load  = 1'b0;
        buf_inval = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Requests are still high during their ack cycle; skip
                // arbitration then so a finished request is not re-granted.
                if (!i_ack_q && !d_ack_q) begin
                    if (i_req && (!data_pending || starve_q == STARVE_MAX)) begin
                        op_d     = OP_FETCH;
                        addr_d   = i_addr;
                        imode_d  = 1'b1;
                        to_err_d = 1'b0;
                        starve_d = '0;
                        if (buf_hit) begin
                            rdata_d = buf_data;
                            state_d = ST_RESP;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else if (data_pending) begin
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        rdata_d  = '0;
                        to_err_d = 1'b0;
                        if (i_req) begin
                            starve_d = starve_q + SC_W'(1);
                        end
                        // Both data requests high is treated as a read.
                        if (d_rd_req) begin
                            op_d    = OP_READ;
                            imode_d = 1'b0;
                        end else begin
                            op_d      = OP_WRITE;
                            imode_d   = d_ispace;
                            buf_inval = d_ispace;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (!m_busy) begin
                    if (op_q == OP_WRITE) begin
                        wr_req_d = 1'b1;
                    end else begin
                        rd_req_d = 1'b1;
                    end
                    state_d = ST_ACCEPT;
                end else if (timed_out) begin
                    to_err_d = 1'b1;
                    rdata_d  = '0;
                    state_d  = ST_RESP;
                end
            end

            ST_ACCEPT: begin
                if (m_busy) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (timed_out) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    to_err_d = 1'b1;
                    rdata_d  = '0;
                    state_d  = ST_RESP;
                end
            end

            ST_DONE: begin
                if (op_q != OP_WRITE && m_read_ready) begin
                    rdata_d = (op_q == OP_FETCH) ? m_rdata
                                                 : {16'h0000, m_rdata[DWORD_W-1:0]};
                    state_d = ST_RESP;
                end else if (op_q == OP_WRITE && !m_busy) begin
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    to_err_d = 1'b1;
                    rdata_d  = '0;
                    state_d  = ST_RESP;
                end
            end

            ST_RESP: begin
                err_d = to_err_q;
                if (op_q == OP_FETCH) begin
                    i_ack_d  = 1'b1;
                    i_data_d = rdata_q;
                    buf_load = !to_err_q;
                end else begin
                    d_ack_d   = 1'b1;
                    d_rdata_d = rdata_q[DWORD_W-1:0];
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
            end
        endcase

        // Wait-state timer restarts on every state change.
        if (state_d != state_q) begin
            to_d = '0;
        end else if (waiting) begin
            to_d = to_q + TO_W'(1);
        end else begin
            to_d = to_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_FETCH;
            addr_q    <= '0;
            wdata_q   <= '0;
            imode_q   <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rdata_q   <= '0;
            to_err_q  <= 1'b0;
            starve_q  <= '0;
            to_q      <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            imode_q   <= imode_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            rdata_q   <= rdata_d;
            to_err_q  <= to_err_d;
            starve_q  <= starve_d;
            to_q      <= to_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_ack        = i_ack_q;
    assign i_data       = i_data_q;
    assign d_ack        = d_ack_q;
    assign d_rdata      = d_rdata_q;
    assign err          = err_q;
    assign m_addr       = addr_q;
    assign m_wdata      = wdata_q;
    assign m_read_req   = rd_req_q;
    assign m_write_req  = wr_req_q;
    assign m_instr_mode = imode_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT      = 1023;
  localparam int TO_W         = 10;
  localparam int LAT_BOUND    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 i_req = 1'b0;
  logic [ADDR_W-1:0]    i_addr = '0;
  logic                 i_ack;
  logic [IWORD_W-1:0]   i_data;
  logic                 d_rd_req = 1'b0;
  logic                 d_wr_req = 1'b0;
  logic [ADDR_W-1:0]    d_addr = '0;
  logic [DWORD_W-1:0]   d_wdata = '0;
  logic                 d_ispace = 1'b0;
  logic                 d_ack;
  logic [DWORD_W-1:0]   d_rdata;
  logic                 err;
  logic [ADDR_W-1:0]    m_addr;
  logic [M_WDATA_W-1:0] m_wdata;
  logic                 m_read_req;
  logic                 m_write_req;
  logic                 m_instr_mode;
  logic                 m_busy = 1'b0;
  logic                 m_read_ready = 1'b0;
  logic [M_RDATA_W-1:0] m_rdata = '0;
  logic [STATE_W-1:0]   dbg_state;

  sdram_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .TIMEOUT      (TIMEOUT),
    .TO_W         (TO_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_data       (i_data),
    .d_rd_req     (d_rd_req),
    .d_wr_req     (d_wr_req),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ispace     (d_ispace),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .err          (err),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_read_req   (m_read_req),
    .m_write_req  (m_write_req),
    .m_instr_mode (m_instr_mode),
    .m_busy       (m_busy),
    .m_read_ready (m_read_ready),
    .m_rdata      (m_rdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard / checking ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int          exp_kind_q[$];   // 1 = fetch ack, 0 = data ack

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- SDRAM memory contents ----------------
  logic [31:0] imem[int];
  logic [15:0] dmem[int];

  function automatic logic [31:0] mem_i(input logic [ADDR_W-1:0] a);
    if (imem.exists(int'(a))) return imem[int'(a)];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [15:0] mem_d(input logic [ADDR_W-1:0] a);
    if (dmem.exists(int'(a))) return dmem[int'(a)];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // ---------------- controller model ----------------
  // Driven on the falling edge; accepts a request, raises busy after 0-1
  // cycles, stays busy 1-4 cycles, then presents read data for one cycle.
  bit               ctl_dead = 1'b0;
  int               c_ph = 0;
  int               c_cnt = 0;
  logic             c_is_rd = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [15:0]      c_wd = '0;
  logic             c_mode = 1'b0;
  int               rd_cnt = 0;
  int               wr_cnt = 0;
  logic             last_mode = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      case (c_ph)
        0: begin
          if (!ctl_dead && (m_read_req || m_write_req)) begin
            c_is_rd   = m_read_req;
            c_addr    = m_addr;
            c_wd      = m_wdata;
            c_mode    = m_instr_mode;
            last_mode = m_instr_mode;
            last_addr = m_addr;
            if (c_is_rd) rd_cnt++; else wr_cnt++;
            c_cnt = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) begin
              m_busy = 1'b1;
              c_ph = 2;
            end else begin
              c_ph = 1;
            end
          end
        end
        1: begin
          check("req_held_until_busy", {31'b0, m_read_req | m_write_req}, 32'd1);
          m_busy = 1'b1;
          c_ph = 2;
        end
        2: begin
          check("req_dropped_after_busy", {31'b0, m_read_req | m_write_req}, 32'd0);
          c_cnt--;
          if (c_cnt == 0) begin
            if (c_is_rd) begin
              m_read_ready = 1'b1;
              m_rdata = c_mode ? mem_i(c_addr) : {16'hFFFF, mem_d(c_addr)};
              c_ph = 3;
            end else begin
              if (c_mode) imem[int'(c_addr)] = {c_wd, ~c_wd};
              else        dmem[int'(c_addr)] = c_wd;
              m_busy = 1'b0;
              c_ph = 0;
            end
          end
        end
        default: begin
          m_read_ready = 1'b0;
          m_rdata = '0;
          m_busy = 1'b0;
          c_ph = 0;
        end
      endcase
    end
  end

  // ---------------- reference model state ----------------
  bit               bv = 1'b0;
  logic [ADDR_W-1:0] btag = '0;
  logic [31:0]      bdata = '0;
  int               starve_m = 0;

  // ---------------- driver tasks ----------------
  task automatic idle_gap();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] a);
    int n;
    int rd0;
    bit hit;
    logic [31:0] exp;
    hit = bv && (btag == a);
    exp = hit ? bdata : mem_i(a);
    rd0 = rd_cnt;
    i_addr = a;
    i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < LAT_BOUND);
    check("fetch_ack", {31'b0, i_ack}, 32'd1);
    check("fetch_data", i_data, exp);
    check("fetch_err", {31'b0, err}, 32'd0);
    check("fetch_sdram_reads", rd_cnt - rd0, hit ? 0 : 1);
    if (hit) check("hit_latency", n, 2);
    else     check("fetch_instr_mode", {31'b0, last_mode}, 32'd1);
    i_req = 1'b0;
    bv = 1'b1; btag = a; bdata = exp;
    starve_m = 0;
    idle_gap();
  endtask

  task automatic do_data(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [15:0] w, input bit isp);
    int n;
    int rd0;
    int wr0;
    bit is_rd;
    logic [15:0] exp;
    is_rd = rd;
    exp = is_rd ? mem_d(a) : 16'h0000;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    d_addr = a; d_wdata = w; d_ispace = isp;
    d_rd_req = rd; d_wr_req = wr;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < LAT_BOUND);
    check("data_ack", {31'b0, d_ack}, 32'd1);
    check("data_err", {31'b0, err}, 32'd0);
    if (is_rd) check("data_rdata", {16'b0, d_rdata}, {16'b0, exp});
    check("data_sdram_reads", rd_cnt - rd0, is_rd ? 1 : 0);
    check("data_sdram_writes", wr_cnt - wr0, is_rd ? 0 : 1);
    check("data_instr_mode", {31'b0, last_mode}, {31'b0, !is_rd && isp});
    check("data_addr", {9'b0, last_addr}, {9'b0, a});
    d_rd_req = 1'b0; d_wr_req = 1'b0; d_ispace = 1'b0;
    if (!is_rd && isp) bv = 1'b0;
    idle_gap();
  endtask

  task automatic do_timeout(input bit fetch, input logic [ADDR_W-1:0] a);
    int n;
    ctl_dead = 1'b1;
    if (fetch) begin i_addr = a; i_req = 1'b1; end
    else begin d_addr = a; d_rd_req = 1'b1; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(fetch ? i_ack : d_ack) && n < TIMEOUT + LAT_BOUND);
    check("to_ack", {31'b0, fetch ? i_ack : d_ack}, 32'd1);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_data_zero", fetch ? i_data : {16'b0, d_rdata}, 32'd0);
    check("to_window", {31'b0, (n >= TIMEOUT) && (n <= TIMEOUT + 8)}, 32'd1);
    i_req = 1'b0; d_rd_req = 1'b0;
    ctl_dead = 1'b0;
    if (fetch) starve_m = 0;
    idle_gap();
  endtask

  // ---------------- global watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [ADDR_W-1:0] pool [5] = '{23'h000010, 23'h000011, 23'h000020, 23'h000123, 23'h7FFFFF};

  initial begin
    int n;
    int got;
    logic [ADDR_W-1:0] a;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_i_ack", {31'b0, i_ack}, 32'd0);
    check("rst_d_ack", {31'b0, d_ack}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_reqs", {30'b0, m_read_req, m_write_req}, 32'd0);
    check("rst_i_data", i_data, 32'd0);
    check("rst_d_rdata", {16'b0, d_rdata}, 32'd0);
    check("rst_state", {29'b0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // fetch miss, then hit returning the buffered (now stale) word
    imem[32'h10] = 32'hDEADBEEF;
    do_fetch(23'h000010);
    imem[32'h10] = 32'h12345678;
    do_fetch(23'h000010);

    // data-space write leaves the buffer alone
    do_data(1'b0, 1'b1, 23'h000123, 16'hA5A5, 1'b0);
    do_fetch(23'h000010);
    // instruction-space write to another address invalidates it
    do_data(1'b0, 1'b1, 23'h000555, 16'h1234, 1'b1);
    do_fetch(23'h000010);
    do_data(1'b1, 1'b0, 23'h000123, 16'h0000, 1'b0);
    // both data requests high behaves as a read
    do_data(1'b1, 1'b1, 23'h000123, 16'hFFFF, 1'b0);

    // starvation: both ports held continuously
    for (int k = 0; k < 8; k++) begin
      if (starve_m == STARVE_LIMIT) begin
        exp_kind_q.push_back(1);
        exp_q.push_back((bv && btag == 23'h000300) ? bdata : mem_i(23'h000300));
        bv = 1'b1; btag = 23'h000300; bdata = mem_i(23'h000300);
        starve_m = 0;
      end else begin
        exp_kind_q.push_back(0);
        exp_q.push_back({16'b0, mem_d(23'h000200)});
        starve_m++;
      end
    end
    i_addr = 23'h000300; i_req = 1'b1;
    d_addr = 23'h000200; d_rd_req = 1'b1;
    n = 0; got = 0;
    while (got < 8 && n < 8 * LAT_BOUND) begin
      @(negedge clk); n++;
      if (i_ack || d_ack) begin
        got++;
        check("starve_order", {31'b0, i_ack}, exp_kind_q.pop_front());
        check("starve_data", i_ack ? i_data : {16'b0, d_rdata}, exp_q.pop_front());
      end
    end
    check("starve_ack_count", got, 8);
    i_req = 1'b0; d_rd_req = 1'b0;
    idle_gap();

    // timeouts, then normal service; a timed-out fetch must not fill the buffer
    do_timeout(1'b0, 23'h000042);
    do_data(1'b1, 1'b0, 23'h000042, 16'h0000, 1'b0);
    do_timeout(1'b1, 23'h077777);
    do_fetch(23'h077777);

    // reset while waiting for controller completion
    imem[32'h1234] = 32'hCAFEF00D;
    i_addr = 23'h001234; i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (dbg_state != ST_DONE && n < LAT_BOUND);
    check("reached_done", {29'b0, dbg_state}, {29'b0, ST_DONE});
    rst_n = 1'b0;
    #1;
    check("mid_rst_reqs", {30'b0, m_read_req, m_write_req}, 32'd0);
    check("mid_rst_acks", {29'b0, i_ack, d_ack, err}, 32'd0);
    check("mid_rst_i_data", i_data, 32'd0);
    check("mid_rst_m_addr", {9'b0, m_addr}, 32'd0);
    check("mid_rst_mode", {31'b0, m_instr_mode}, 32'd0);
    check("mid_rst_state", {29'b0, dbg_state}, 32'd0);
    i_req = 1'b0;
    bv = 1'b0; starve_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (c_ph != 0 && n < LAT_BOUND) begin @(negedge clk); n++; end
    do_fetch(23'h001234);
    do_fetch(23'h001234);

    // randomized single-port traffic
    for (int t = 0; t < 40; t++) begin
      a = pool[$urandom_range(0, 4)];
      case ($urandom_range(0, 2))
        0: do_fetch(a);
        1: do_data(1'b1, 1'b0, a, 16'h0000, 1'b0);
        default: do_data(1'b0, 1'b1, a, 16'($urandom), ($urandom_range(0, 3) == 0));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- CPU-clock-domain front end that sits directly upstream of the SDRAM controller.
- Merges the CPU instruction-fetch port and the data load/store port into the controller's single request interface: one request in flight, level requests, pulsed completion.
- Holds a one-entry instruction buffer so repeated fetches of the same 32-bit instruction complete without an SDRAM access.
- Runs on the same clock the controller receives as its CPU-side sampling clock.

Parameters:
- STARVE_LIMIT, 3, consecutive data grants allowed while a fetch waits before the fetch is forced through.
- TIMEOUT, 1023, cycles allowed in any wait state before the access is aborted with an error.
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  CPU clock, same clock the controller uses to sample requests.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  instruction fetch request; level, held with i_addr until i_ack.
- i_addr  in  23  instruction word address (32-bit words).
- i_ack  out  1  one-cycle pulse: fetch complete.
- i_data  out  32  fetched instruction, valid while i_ack=1.
- d_rd_req  in  1  data read request; level, held with d_addr until d_ack.
- d_wr_req  in  1  data write request; level, held with d_addr, d_wdata and d_ispace until d_ack.
- d_addr  in  23  data address (16-bit words).
- d_wdata  in  16  write data.
- d_ispace  in  1  1 = the write targets instruction space (program loader).
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  16  read data, valid while d_ack=1.
- err  out  1  one-cycle pulse together with an ack when the access timed out.
- m_addr  out  23  controller address.
- m_wdata  out  16  controller write data.
- m_read_req  out  1  controller read request.
- m_write_req  out  1  controller write request.
- m_instr_mode  out  1  controller instruction-mode select.
- m_busy  in  1  controller busy.
- m_read_ready  in  1  controller read data valid.
- m_rdata  in  32  controller read data.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE.
  - All m_* requests low; i_ack, d_ack, err low; i_data, d_rdata zero.
  - Buffer invalid; starve count 0.
- State machine: IDLE -> ISSUE -> ACCEPT -> DONE -> RESP -> IDLE.
- IDLE arbitration, evaluated only when neither ack is asserted:
  - d_rd_req and d_wr_req both high is a protocol error; treat it as a read.
  - A data request wins over i_req unless starve count == STARVE_LIMIT, in which case the fetch wins.
  - A data grant while i_req is pending increments the starve count; any fetch grant clears it.
- Buffer hit: i_req granted, buffer valid and i_addr equals the buffered tag.
  - Go straight to RESP; i_ack is asserted the next cycle with the buffered data.
  - No SDRAM access is made.
- ISSUE (one cycle):
  - Drive m_addr and m_wdata.
  - m_instr_mode = 1 for fetches; = d_ispace for writes; = 0 for data reads.
  - Assert m_read_req or m_write_req only if m_busy=0; otherwise stay in ISSUE.
- ACCEPT:
  - Hold the request high until m_busy=1 is seen, then drop it.
- DONE:
  - A read completes on the first cycle m_read_ready=1. Capture m_rdata; fetches keep all 32 bits, data reads keep [15:0].
  - A write completes on the first cycle m_busy=0.
- RESP (one cycle):
  - Pulse the matching ack with its data.
  - A fetch loads the buffer (tag = i_addr, data).
- Write invalidation:
  - A write with d_ispace=1 invalidates the buffer when it enters ISSUE, regardless of address.
  - Data-space writes never touch the buffer.
- Timeout:
  - The counter is cleared on every state change and counts in ISSUE, ACCEPT and DONE.
  - Reaching TIMEOUT: drop requests, go to RESP, pulse the ack with err=1 and data zero.
  - A timed-out fetch does not load the buffer.
- A request that drops before its ack has undefined results; the arbiter still completes the in-flight SDRAM access.
- Reset mid-access returns to IDLE immediately; the controller finishes independently.
- Latency from grant to ack:
  - Buffer hit: 2 cycles.
  - Miss: 3 + controller latency.

Decomposition:
- Shared package sdram_pkg:
  - arbiter state encoding;
  - address widths: SDRAM address = 23, instruction word = 32, data word = 16;
  - the controller's request/response signal bundle widths.
- One natural sub-module: ibuf_entry (tag/data/valid register with hit compare and invalidate).

Test Plan:
- Fetch i_addr=0x000010 with the model returning 0xDEADBEEF -> i_ack one cycle, i_data=0xDEADBEEF, m_instr_mode=1. Refetch of 0x000010 -> i_ack 2 cycles after grant, no m_read_req.
- Data write d_addr=0x000123, d_wdata=0xA5A5, d_ispace=0 -> m_write_req held until m_busy=1; d_ack after m_busy falls; m_instr_mode=0; buffer remains valid.
- Write with d_ispace=1 to any address after a fetch of 0x10 -> refetch of 0x10 issues m_read_req.
- d_rd_req and i_req both held continuously -> grants D,D,D,I,D,D,D,I (STARVE_LIMIT=3).
- Model never raises m_busy -> err and d_ack pulse together after TIMEOUT cycles; the next request is served normally.
- rst_n low while in DONE -> all outputs zero immediately; after release, a new fetch completes correctly.
